// File: rtl/idelay_pkg.sv
// Shared constants and FSM encoding for the delay-tap scan controller.
package idelay_pkg;

    localparam int TAP_W       = 5;
    localparam int NTAPS       = 32;
    localparam int LOAD_CYCLES = 2;
    localparam int GAP_CYCLES  = 2;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        GAP,
        SETTLE,
        SAMPLE,
        NEXT,
        EVAL,
        APPLY_LOAD,
        APPLY_GAP,
        FIN
    } state_t;

endpackage

// File: rtl/pass_run_finder.sv
// Serial longest-run-of-ones search over the tap pass map, one bit per cycle.
module pass_run_finder
    import idelay_pkg::*;
(
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             start,
    input  logic [NTAPS-1:0] pass_map,
    output logic             done,
    output logic [TAP_W-1:0] run_start,
    output logic [TAP_W:0]   run_len,
    output logic [TAP_W-1:0] centre
);

    logic             busy;
    logic [TAP_W-1:0] idx;
    logic [TAP_W-1:0] cur_start, cur_start_nxt, best_start, best_start_nxt;
    logic [TAP_W:0]   cur_len, cur_len_nxt, best_len, best_len_nxt;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        cur_start_nxt  = cur_start;
        cur_len_nxt    = cur_len;
        best_start_nxt = best_start;
        best_len_nxt   = best_len;
        if (busy) begin
            if (pass_map[idx]) begin
                if (cur_len == '0) cur_start_nxt = idx;
                cur_len_nxt = cur_len + 1'b1;
                // Strictly longer only, so the lowest-starting run keeps a tie.
                if (cur_len_nxt > best_len) begin
                    best_len_nxt   = cur_len_nxt;
                    best_start_nxt = cur_start_nxt;
                end
            end else begin
                cur_len_nxt = '0;
            end
        end
    end

    // Results come from the next-state values so they are final in the done cycle.
    assign done      = busy && (idx == TAP_W'(NTAPS - 1));
    assign run_start = best_start_nxt;
    assign run_len   = best_len_nxt;
    assign centre    = (best_len_nxt == '0) ? '0
                     : best_start_nxt + TAP_W'((best_len_nxt - 1'b1) >> 1);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            busy       <= 1'b0;
            idx        <= '0;
            cur_start  <= '0;
            cur_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
        end else if (start) begin
            busy       <= 1'b1;
            idx        <= '0;
            cur_start  <= '0;
            cur_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
        end else if (busy) begin
            cur_start  <= cur_start_nxt;
            cur_len    <= cur_len_nxt;
            best_start <= best_start_nxt;
            best_len   <= best_len_nxt;
            idx        <= idx + 1'b1;
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/idelay_scan.sv
// Delay-tap programming front end: manual tap writes and per-channel eye scan
// that loads the centre of the widest passing tap window.
module idelay_scan
    import idelay_pkg::*;
#(
    parameter int NINPUT        = 20,
    parameter int NOUTPUT       = 1,
    parameter int SETTLE_CYCLES = 16,
    parameter int SAMPLE_CYCLES = 256,
    parameter int ERR_THRESHOLD = 0
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              START,
    input  logic [7:0]        SCAN_CHANNEL,
    input  logic              WR_EN,
    input  logic [7:0]        WR_CHANNEL,
    input  logic [4:0]        WR_VALUE,
    input  logic [NINPUT-1:0] DATA_IN,
    input  logic              EXP_IN,
    output logic [7:0]        DELAY_CHANNEL,
    output logic [4:0]        DELAY_VALUE,
    output logic              DELAY_UPDATE,
    output logic              BUSY,
    output logic              DONE,
    output logic              FAIL,
    output logic [4:0]        RESULT_TAP,
    output logic [5:0]        RESULT_WIDTH,
    output logic [31:0]       PASS_MAP
);

    localparam int          CH_W        = (NINPUT > 1) ? $clog2(NINPUT) : 1;
    localparam logic [8:0]  N_SCAN      = 9'(NINPUT);
    localparam logic [8:0]  N_WRITE     = 9'(NINPUT + NOUTPUT);
    localparam logic [15:0] LOAD_LAST   = 16'(LOAD_CYCLES - 1);
    localparam logic [15:0] GAP_LAST    = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] SAMPLE_LAST = 16'(SAMPLE_CYCLES - 1);
    localparam logic [15:0] ERR_LIMIT   = 16'(ERR_THRESHOLD);
    localparam logic [4:0]  LAST_TAP    = 5'(NTAPS - 1);

    state_t      state, state_next;
    logic [15:0] cnt;
    logic [15:0] err_cnt;
    logic [4:0]  tap;
    logic [7:0]  scan_chan;
    logic        data_q, exp_q;
    logic        scan_ok, wr_ok;
    logic        finder_start, finder_done;
    logic [4:0]  finder_centre;
    logic [5:0]  finder_len;
    logic [4:0]  run_start_unused;

    assign scan_ok      = {1'b0, SCAN_CHANNEL} < N_SCAN;
    assign wr_ok        = {1'b0, WR_CHANNEL} < N_WRITE;
    assign finder_start = (state == NEXT) && (tap == LAST_TAP);

    pass_run_finder u_finder (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .start     (finder_start),
        .pass_map  (PASS_MAP),
        .done      (finder_done),
        .run_start (run_start_unused),
        .run_len   (finder_len),
        .centre    (finder_centre)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (START)      state_next = scan_ok ? LOAD : FIN;
                else if (WR_EN) state_next = wr_ok ? APPLY_LOAD : FIN;
            end
            LOAD:       if (cnt == LOAD_LAST)   state_next = GAP;
            GAP:        if (cnt == GAP_LAST)    state_next = SETTLE;
            SETTLE:     if (cnt == SETTLE_LAST) state_next = SAMPLE;
            SAMPLE:     if (cnt == SAMPLE_LAST) state_next = NEXT;
            NEXT:       state_next = (tap == LAST_TAP) ? EVAL : LOAD;
            EVAL:       if (finder_done)        state_next = APPLY_LOAD;
            APPLY_LOAD: if (cnt == LOAD_LAST)   state_next = APPLY_GAP;
            APPLY_GAP:  if (cnt == GAP_LAST)    state_next = FIN;
            FIN:        state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state         <= IDLE;
            cnt           <= '0;
            err_cnt       <= '0;
            tap           <= '0;
            scan_chan     <= '0;
            data_q        <= 1'b0;
            exp_q         <= 1'b0;
            DELAY_CHANNEL <= '0;
            DELAY_VALUE   <= '0;
            DELAY_UPDATE  <= 1'b0;
            BUSY          <= 1'b0;
            DONE          <= 1'b0;
            FAIL          <= 1'b0;
            RESULT_TAP    <= '0;
            RESULT_WIDTH  <= '0;
            PASS_MAP      <= '0;
        end else begin
            state        <= state_next;
            cnt          <= (state_next != state || state == IDLE) ? '0 : cnt + 16'd1;
            data_q       <= DATA_IN[scan_chan[CH_W-1:0]];
            exp_q        <= EXP_IN;
            // Update strobe and busy flag are registered from the next state.
            DELAY_UPDATE <= (state_next == LOAD) || (state_next == APPLY_LOAD);
            BUSY         <= (state_next != IDLE);
            DONE         <= (state == FIN);

            case (state)
                IDLE: begin
                    if (START) begin
                        FAIL <= !scan_ok;
                        if (scan_ok) begin
                            scan_chan     <= SCAN_CHANNEL;
                            tap           <= '0;
                            err_cnt       <= '0;
                            PASS_MAP      <= '0;
                            DELAY_CHANNEL <= SCAN_CHANNEL;
                            DELAY_VALUE   <= '0;
                        end
                    end else if (WR_EN) begin
                        FAIL <= !wr_ok;
                        if (wr_ok) begin
                            DELAY_CHANNEL <= WR_CHANNEL;
                            DELAY_VALUE   <= WR_VALUE;
                            RESULT_TAP    <= WR_VALUE;
                        end
                    end
                end
                SAMPLE: begin
                    if ((data_q ^ exp_q) && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                end
                NEXT: begin
                    PASS_MAP[tap] <= (err_cnt <= ERR_LIMIT);
                    err_cnt       <= '0;
                    if (tap != LAST_TAP) begin
                        tap         <= tap + 1'b1;
                        DELAY_VALUE <= tap + 1'b1;
                    end
                end
                EVAL: begin
                    if (finder_done) begin
                        DELAY_VALUE  <= finder_centre;
                        RESULT_TAP   <= finder_centre;
                        RESULT_WIDTH <= finder_len;
                        FAIL         <= (finder_len == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
